// File: rtl/dmem_port_arbiter_pkg.sv
// Shared constants for the two-port data-memory arbiter: FSM encoding,
// requester ids and default bus widths.
package dmem_port_arbiter_pkg;

    localparam int DEF_ADDR_W = 8;
    localparam int DEF_DATA_W = 8;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic PORT_LSU   = 1'b0;
    localparam logic PORT_FETCH = 1'b1;

    function automatic logic other_port(input logic id);
        return ~id;
    endfunction

endpackage

// File: rtl/dmem_port_arbiter_if.sv
// Request/ack handshake bundle for one memory requester; the requester is
// the master, the arbiter the slave.
interface dmem_port_arbiter_if
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic              req;
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] wdata;
    logic              ack;
    logic [DATA_W-1:0] rdata;

    modport master (output req, output we, output addr, output wdata,
                    input  ack, input  rdata);
    modport slave  (input  req, input  we, input  addr, input  wdata,
                    output ack, output rdata);
endinterface

// File: rtl/dmem_port_arbiter_rr_pick2.sv
// Combinational two-way round-robin picker: on a tie the port that did not
// win last time is chosen.
module dmem_port_arbiter_rr_pick2 (
    input  logic [1:0] i_req,
    input  logic       i_last_grant,
    output logic       o_valid,
    output logic       o_winner
);
    assign o_valid  = |i_req;
    assign o_winner = (&i_req) ? ~i_last_grant : i_req[1];
endmodule

// File: rtl/dmem_port_arbiter.sv
// Arbiter/sequencer for a single-port 256x8 memory shared by the load/store
// unit (r0) and instruction fetch (r1): IDLE -> BUSY (memory access) -> RESP (ack).
module dmem_port_arbiter
    import dmem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
) (
    input  logic                   clk,
    input  logic                   rst,
    dmem_port_arbiter_if.slave     r0,
    dmem_port_arbiter_if.slave     r1,
    output logic                   mem_write,
    output logic [ADDR_W-1:0]      mem_addr,
    output logic [DATA_W-1:0]      mem_wdata,
    input  logic [DATA_W-1:0]      mem_rdata
);

    logic [1:0]        r_state;
    logic              r_last_grant;
    logic              r_id;
    logic              r_we;
    logic [ADDR_W-1:0] r_addr;
    logic [DATA_W-1:0] r_wdata;
    logic [DATA_W-1:0] r_rdata;

    logic [1:0]        w_req;
    logic              w_valid;
    logic              w_winner;
    logic              w_sel_we;
    logic [ADDR_W-1:0] w_sel_addr;
    logic [DATA_W-1:0] w_sel_wdata;
    logic              w_resp;

    // In RESP only the port that was not just served may be picked up.
    always_comb begin
        w_req = 2'b00;
        case (r_state)
            ST_IDLE: w_req = {r1.req, r0.req};
            ST_RESP: w_req = other_port(r_id) ? {r1.req, 1'b0} : {1'b0, r0.req};
            default: w_req = 2'b00;
        endcase
    end

    dmem_port_arbiter_rr_pick2 u_pick (
        .i_req        (w_req),
        .i_last_grant (r_last_grant),
        .o_valid      (w_valid),
        .o_winner     (w_winner)
    );

    assign w_sel_we    = w_winner ? r1.we    : r0.we;
    assign w_sel_addr  = w_winner ? r1.addr  : r0.addr;
    assign w_sel_wdata = w_winner ? r1.wdata : r0.wdata;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state      <= ST_IDLE;
            r_last_grant <= PORT_FETCH;
            r_id         <= 1'b0;
            r_we         <= 1'b0;
            r_addr       <= '0;
            r_wdata      <= '0;
            r_rdata      <= '0;
        end else begin
            case (r_state)
                ST_IDLE, ST_RESP: begin
                    if (w_valid) begin
                        r_id         <= w_winner;
                        r_last_grant <= w_winner;
                        r_we         <= w_sel_we;
                        r_addr       <= w_sel_addr;
                        r_wdata      <= w_sel_wdata;
                        r_state      <= ST_BUSY;
                    end else begin
                        r_state      <= ST_IDLE;
                    end
                end
                // Asynchronous read: rdata is sampled before the write lands.
                ST_BUSY: begin
                    r_rdata <= mem_rdata;
                    r_state <= ST_RESP;
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    // Address/data follow the latched request, so they hold outside BUSY.
    assign mem_write = (r_state == ST_BUSY) && r_we && !rst;
    assign mem_addr  = r_addr;
    assign mem_wdata = r_wdata;

    assign w_resp   = (r_state == ST_RESP);
    assign r0.ack   = w_resp && (r_id == PORT_LSU);
    assign r1.ack   = w_resp && (r_id == PORT_FETCH);
    assign r0.rdata = w_resp ? r_rdata : '0;
    assign r1.rdata = w_resp ? r_rdata : '0;

endmodule

// File: doc/dmem_port_arbiter.md
Name: dmem_port_arbiter

Overview:
- Two-requester arbiter and sequencer for the 256x8 single-port data memory (synchronous write, asynchronous read).
- Port 0 is the execute-stage load/store unit; port 1 is the instruction fetch unit. Program and data share the one memory.
- Registers each winning request, drives the memory for exactly one cycle, captures read data and returns a one-cycle ack.
- Round-robin on contention, so neither requester starves.

Parameters:
- ADDR_W, 8, memory address width (256 locations)
- DATA_W, 8, memory data width

Ports:
- clk  in  1  system clock, rising-edge
- rst  in  1  asynchronous, active-high reset
- r0_req  in  1  port 0 request; held high with r0_we/r0_addr/r0_wdata stable until r0_ack
- r0_we  in  1  port 0 write (1) / read (0)
- r0_addr  in  ADDR_W  port 0 address
- r0_wdata  in  DATA_W  port 0 write data
- r0_ack  out  1  one-cycle completion pulse for port 0
- r0_rdata  out  DATA_W  read data; valid only while r0_ack=1
- r1_req, r1_we, r1_addr, r1_wdata, r1_ack, r1_rdata: same as port 0, for port 1
- mem_write  out  1  to memory write enable
- mem_addr  out  ADDR_W  to memory address
- mem_wdata  out  DATA_W  to memory write data
- mem_rdata  in  DATA_W  from memory asynchronous read data

Behaviour:
- Clock and reset: one clock, clk; reset rst is asynchronous and active-high.
- Reset state: state=IDLE, last_grant=1 (port 0 wins the first tie), all captured registers 0. Outputs mem_write, mem_addr, mem_wdata, r0_ack, r1_ack, r0_rdata and r1_rdata are all 0.
- Reset takes effect immediately: mem_write drops combinationally even mid-BUSY, and any in-flight transaction is discarded with no ack.
- State machine has three states: IDLE, BUSY, RESP.
- IDLE, at each posedge:
  - If no req: stay in IDLE.
  - If exactly one req: latch that requester's id/we/addr/wdata and go to BUSY.
  - If both req: pick the port != last_grant, latch it and go to BUSY.
  - last_grant is updated when the winner is latched.
- BUSY:
  - mem_addr=addr_q and mem_wdata=wdata_q; mem_write=we_q for this cycle only.
  - At the posedge, capture mem_rdata into rdata_q and go to RESP.
  - For a write, rdata_q holds the pre-write contents (async read before the sync write). The bench ignores it.
- RESP:
  - Assert ack for the latched id; rdata_q drives both rN_rdata.
  - The acked requester's req is ignored in this cycle.
  - At the posedge, if the other port's req=1, latch it and go straight to BUSY (back-to-back, round-robin). Otherwise go to IDLE.
- Outside BUSY: mem_write=0, and mem_addr/mem_wdata hold their last values.
- Outside RESP: both acks=0 and both rN_rdata=0.
- Latency: req seen at posedge T gives BUSY in cycle T+1 and ack in cycle T+2.
- Throughput: one access per 2 cycles under alternating contention; one per 3 cycles for a single requester streaming.
- Both acks are never high together, and mem_write is never high outside BUSY.
- Request rules:
  - A requester may drop req, or present a new request, only after seeing ack.
  - Dropping req before ack is illegal; the arbiter still completes the latched transaction, and the bench flags the violation.
- Address wrap: none. The full 8-bit address is passed through unchanged; 0xFF is a legal address.

Decomposition:
- Shared package holds:
  - state encoding constants ST_IDLE=2'd0, ST_BUSY=2'd1, ST_RESP=2'd2
  - port id constants PORT_LSU=1'b0, PORT_FETCH=1'b1
  - default ADDR_W/DATA_W
- One sub-module is natural: rr_pick2. It is a combinational 2-way round-robin picker with inputs req[1:0] and last_grant, and outputs valid and winner.
- Everything else stays in dmem_port_arbiter.

Test Plan:
- Port 0 writes 0x5A to 0x10, then port 0 reads 0x10:
  - mem_write high for exactly 1 cycle.
  - First r0_ack 2 cycles after req is sampled.
  - Read ack carries r0_rdata=0x5A.
- Both ports request at the same posedge (port 0 read 0x00, port 1 read 0x01) after reset:
  - Port 0 is served first; r1_ack follows r0_ack by exactly 2 cycles.
  - The two acks never overlap.
- Both ports hold req continuously for 8 transactions:
  - Grants alternate 0,1,0,1...
  - Each port gets 4 acks and mem_write never asserts spuriously.
- Port 1 read of 0xFF while port 0 writes 0x33 to 0xFF, port 0 winning:
  - Port 1 returns 0x33.
  - Port 0's write ack shows rdata equal to the prior contents of 0xFF.
- rst asserted during BUSY of a write to 0x20:
  - mem_write falls immediately and no ack is issued.
  - After release, a read of 0x20 returns either the old or the new value, never X. The bench checks state=IDLE.
- Single requester streaming 3 reads from 0x00, 0x01, 0x02:
  - Acks spaced 3 cycles apart.
  - rdata matches the program.mem contents.
